// File: rtl/secure_serdes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : secure_serdes_pkg
//  Description : Shared definitions for the secure SERDES encryptor and
//                decryptor cores: frame width, key slice width and the
//                2-bit frame sequencer state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package secure_serdes_pkg;

    // Frame width. The 3-bit bit counters in the cores assume 8.
    localparam int DATA_W    = 8;

    // Only the low KEY_LSB_W bits of the shared key take part in the XOR.
    localparam int KEY_LSB_W = 8;

    localparam int STATE_W   = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        DECRYPT = 2'd2,
        OUTPUT  = 2'd3
    } state_t;

endpackage : secure_serdes_pkg
`default_nettype wire

// File: rtl/secure_serdes_decryptor_core_if.sv
`default_nettype none
// ============================================================================
//  Module      : secure_serdes_decryptor_core_if
//  Description : Frame request, serial inputs and result/status bundle of the
//                decryptor core.
//                master : drives start, key, cipher_bit, b_bit
//                slave  : drives plain_byte, plain_valid, plain_out, busy,
//                         done, start_err
//  Revision    : 1.0 - initial release
// ============================================================================
interface secure_serdes_decryptor_core_if #(
    parameter int DATA_W = secure_serdes_pkg::DATA_W,
    parameter int KEY_W  = 128
);

    logic              start;
    logic [KEY_W-1:0]  key;
    logic              cipher_bit;
    logic              b_bit;
    logic [DATA_W-1:0] plain_byte;
    logic              plain_valid;
    logic              plain_out;
    logic              busy;
    logic              done;
    logic              start_err;

    modport master (
        output start, key, cipher_bit, b_bit,
        input  plain_byte, plain_valid, plain_out, busy, done, start_err
    );

    modport slave (
        input  start, key, cipher_bit, b_bit,
        output plain_byte, plain_valid, plain_out, busy, done, start_err
    );

endinterface : secure_serdes_decryptor_core_if
`default_nettype wire

// File: rtl/secure_serdes_shift8.sv
`default_nettype none
// ============================================================================
//  Module      : secure_serdes_shift8
//  Description : MSB-first shift register with synchronous clear and parallel
//                load. Priority: clear > load > shift. Bits enter at bit 0
//                and leave from bit WIDTH-1.
//  Ports       : clk, rst_n (async, active-low)
//                i_clr, i_load, i_load_data, i_shift_en, i_shift_in
//                o_q : current register contents
//  Revision    : 1.0 - initial release
// ============================================================================
module secure_serdes_shift8 #(
    parameter int WIDTH = secure_serdes_pkg::DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_data,
    input  logic             i_shift_en,
    input  logic             i_shift_in,
    output logic [WIDTH-1:0] o_q
);

    import secure_serdes_pkg::*;

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_load_data;
        end else if (i_shift_en) begin
            r_q <= {r_q[WIDTH-2:0], i_shift_in};
        end
    end

    assign o_q = r_q;

endmodule : secure_serdes_shift8
`default_nettype wire

// File: rtl/tt_um_secure_serdes_decryptor.sv
`default_nettype none
// ============================================================================
//  Module      : tt_um_secure_serdes_decryptor
//  Description : Tiny Tapeout pin wrapper around the decryptor core.
//                ui_in[0]=start, ui_in[1]=cipher_bit, ui_in[2]=b_bit
//                uo_out[0]=plain_out, [1]=done, [2]=busy, [3]=start_err
//                uio_out=plain_byte, uio_oe=0xFF (always driven)
//                The key is a build-time constant since no pins carry it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tt_um_secure_serdes_decryptor #(
    parameter logic [127:0] KEY_VALUE = 128'h5A
) (
    input  wire [7:0] ui_in,
    output wire [7:0] uo_out,
    input  wire [7:0] uio_in,
    output wire [7:0] uio_out,
    output wire [7:0] uio_oe,
    input  wire       ena,
    input  wire       clk,
    input  wire       rst_n
);

    secure_serdes_decryptor_core_if #(.DATA_W(8), .KEY_W(128)) w_bus ();

    wire w_unused;

    assign w_bus.start      = ui_in[0];
    assign w_bus.cipher_bit = ui_in[1];
    assign w_bus.b_bit      = ui_in[2];
    assign w_bus.key        = KEY_VALUE;

    secure_serdes_decryptor_core #(.DATA_W(8), .KEY_W(128)) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (w_bus)
    );

    assign uo_out  = {4'b0000, w_bus.start_err, w_bus.busy, w_bus.done, w_bus.plain_out};
    assign uio_out = w_bus.plain_byte;
    assign uio_oe  = 8'hFF;

    assign w_unused = &{ena, uio_in, ui_in[7:3], 1'b0};

endmodule : tt_um_secure_serdes_decryptor
`default_nettype wire

// File: rtl/secure_serdes_decryptor_core.sv
`default_nettype none
// ============================================================================
//  Module      : secure_serdes_decryptor_core
//  Description : Receive-side secure SERDES core. Deserialises 8 cipher bits
//                and 8 B-operand bits (MSB first), recovers
//                A = cipher ^ B ^ key[7:0], presents A in parallel with a
//                one-cycle valid pulse and re-serialises it MSB first.
//  Ports       : clk, rst_n (async, active-low)
//                bus (slave) : start, key, cipher_bit, b_bit in;
//                              plain_byte, plain_valid, plain_out, busy,
//                              done, start_err out
//  Revision    : 1.0 - initial release
// ============================================================================
module secure_serdes_decryptor_core #(
    parameter int DATA_W = secure_serdes_pkg::DATA_W,
    parameter int KEY_W  = 128
) (
    input  logic                           clk,
    input  logic                           rst_n,
    secure_serdes_decryptor_core_if.slave  bus
);

    import secure_serdes_pkg::*;

    state_t            r_state;
    logic [2:0]        r_bit_cnt;
    logic              r_start_d;
    logic [DATA_W-1:0] r_plain_byte;
    logic              r_plain_valid;
    logic              r_plain_out;
    logic              r_busy;
    logic              r_done;
    logic              r_start_err;

    logic [KEY_W-1:0]  w_key;
    logic              w_unused_key;
    logic              w_accept;
    logic              w_shift_in;
    logic              w_load_out;
    logic              w_shift_out;
    logic [DATA_W-1:0] w_c_q;
    logic [DATA_W-1:0] w_b_q;
    logic [DATA_W-1:0] w_out_q;
    logic [DATA_W-1:0] w_plain;

    assign w_key        = bus.key;
    // Upper key bits are deliberately ignored; folded here so they are not
    // mistaken for dangling logic.
    assign w_unused_key = ^w_key[KEY_W-1:KEY_LSB_W];

    assign w_accept    = (r_state == IDLE) && bus.start;
    assign w_shift_in  = (r_state == SHIFT);
    assign w_load_out  = (r_state == DECRYPT);
    assign w_shift_out = (r_state == OUTPUT);

    assign w_plain = w_c_q ^ w_b_q ^ w_key[KEY_LSB_W-1:0];

    // Cipher input register, cleared when a frame is accepted.
    secure_serdes_shift8 #(.WIDTH(DATA_W)) u_c_shreg (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clr       (w_accept),
        .i_load      (1'b0),
        .i_load_data ({DATA_W{1'b0}}),
        .i_shift_en  (w_shift_in),
        .i_shift_in  (bus.cipher_bit),
        .o_q         (w_c_q)
    );

    // B operand input register, bit-aligned with the cipher register.
    secure_serdes_shift8 #(.WIDTH(DATA_W)) u_b_shreg (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clr       (w_accept),
        .i_load      (1'b0),
        .i_load_data ({DATA_W{1'b0}}),
        .i_shift_en  (w_shift_in),
        .i_shift_in  (bus.b_bit),
        .o_q         (w_b_q)
    );

    // Plaintext output register: loaded in DECRYPT, drained zero-filled.
    secure_serdes_shift8 #(.WIDTH(DATA_W)) u_out_shreg (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clr       (1'b0),
        .i_load      (w_load_out),
        .i_load_data (w_plain),
        .i_shift_en  (w_shift_out),
        .i_shift_in  (1'b0),
        .o_q         (w_out_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_bit_cnt     <= 3'd0;
            r_start_d     <= 1'b0;
            r_plain_byte  <= '0;
            r_plain_valid <= 1'b0;
            r_plain_out   <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_start_err   <= 1'b0;
        end else begin
            r_plain_valid <= 1'b0;
            r_start_d     <= bus.start;

            // A start request made while a frame is in flight is a protocol
            // error. Only a new assertion counts, so a start held high
            // continuously to chain back-to-back frames is not flagged.
            if (bus.start && !r_start_d && (r_state != IDLE)) begin
                r_start_err <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_bit_cnt <= 3'd0;
                        r_done    <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        r_state <= DECRYPT;
                    end
                end
                DECRYPT: begin
                    r_plain_byte  <= w_plain;
                    r_plain_valid <= 1'b1;
                    r_bit_cnt     <= 3'd0;
                    r_state       <= OUTPUT;
                end
                OUTPUT: begin
                    r_plain_out <= w_out_q[DATA_W-1];
                    r_bit_cnt   <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.plain_byte  = r_plain_byte;
    assign bus.plain_valid = r_plain_valid;
    assign bus.plain_out   = r_plain_out;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.start_err   = r_start_err;

endmodule : secure_serdes_decryptor_core
`default_nettype wire

// File: tb/tb_secure_serdes_decryptor_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_secure_serdes_decryptor_core
//  Description : Directed self-checking bench for the decryptor core and its
//                pin wrapper. Inputs change and outputs are sampled on the
//                falling clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_secure_serdes_decryptor_core;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    secure_serdes_decryptor_core_if #(.DATA_W(8), .KEY_W(128)) bus ();

    secure_serdes_decryptor_core #(.DATA_W(8), .KEY_W(128)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0] tt_uo;
    logic [7:0] tt_uio_out;
    logic [7:0] tt_uio_oe;

    tt_um_secure_serdes_decryptor #(.KEY_VALUE(128'h5A)) u_tt (
        .ui_in   ({5'b00000, bus.b_bit, bus.cipher_bit, bus.start}),
        .uo_out  (tt_uo),
        .uio_in  (8'h00),
        .uio_out (tt_uio_out),
        .uio_oe  (tt_uio_oe),
        .ena     (1'b1),
        .clk     (clk),
        .rst_n   (rst_n)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] f_byte;
    logic [7:0] f_ser;
    logic       f_v9;
    logic       f_v10;
    logic       f_done;
    logic       f_busy;

    // One full frame starting at the next falling edge. pulse_t names the
    // edge (1..9) at which start is additionally sampled high; 0 for none.
    task automatic drive_frame(input logic [7:0] c, input logic [7:0] b, input int pulse_t,
                               output logic [7:0] byte_e9, output logic valid_e9,
                               output logic valid_e10, output logic [7:0] ser,
                               output logic done_e17, output logic busy_mid);
        @(negedge clk);
        bus.start = 1'b1;
        busy_mid  = 1'b0;
        for (int t = 1; t <= 8; t++) begin
            @(negedge clk);
            bus.start      = (t == pulse_t);
            bus.cipher_bit = c[8-t];
            bus.b_bit      = b[8-t];
            if (t == 4) busy_mid = bus.busy;
        end
        @(negedge clk);
        bus.cipher_bit = 1'b0;
        bus.b_bit      = 1'b0;
        bus.start      = (pulse_t == 9);
        @(negedge clk);
        bus.start = 1'b0;
        byte_e9   = bus.plain_byte;
        valid_e9  = bus.plain_valid;
        valid_e10 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) valid_e10 = bus.plain_valid;
            ser[7-k] = bus.plain_out;
        end
        done_e17 = bus.done;
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.cipher_bit = 1'b0; bus.b_bit = 1'b0; bus.key = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if (bus.plain_byte !== 8'h00) begin n_err++; $display("FAIL reset_plain_byte: got %h want 00", bus.plain_byte); end
        n_vec++; if (bus.plain_valid !== 1'b0) begin n_err++; $display("FAIL reset_plain_valid: got %b want 0", bus.plain_valid); end
        n_vec++; if (bus.plain_out !== 1'b0) begin n_err++; $display("FAIL reset_plain_out: got %b want 0", bus.plain_out); end
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", bus.done); end
        n_vec++; if (bus.start_err !== 1'b0) begin n_err++; $display("FAIL reset_start_err: got %b want 0", bus.start_err); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        bus.key = 128'h5A;
        drive_frame(8'hC3, 8'hA5, 0, f_byte, f_v9, f_v10, f_ser, f_done, f_busy);
        n_vec++; if (f_byte !== 8'h3C) begin n_err++; $display("FAIL basic_byte: got %h want 3c", f_byte); end
        n_vec++; if (f_v9 !== 1'b1) begin n_err++; $display("FAIL basic_valid_e9: got %b want 1", f_v9); end
        n_vec++; if (f_v10 !== 1'b0) begin n_err++; $display("FAIL basic_valid_e10: got %b want 0", f_v10); end
        n_vec++; if (f_ser !== 8'h3C) begin n_err++; $display("FAIL basic_serial: got %h want 3c", f_ser); end
        n_vec++; if (f_done !== 1'b1) begin n_err++; $display("FAIL basic_done: got %b want 1", f_done); end
        n_vec++; if (f_busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_mid: got %b want 1", f_busy); end
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_end: got %b want 0", bus.busy); end
        n_vec++; if (tt_uio_out !== 8'h3C) begin n_err++; $display("FAIL wrap_uio_out: got %h want 3c", tt_uio_out); end
        n_vec++; if (tt_uio_oe !== 8'hFF) begin n_err++; $display("FAIL wrap_uio_oe: got %h want ff", tt_uio_oe); end
        n_vec++; if (tt_uo !== 8'h02) begin n_err++; $display("FAIL wrap_uo_out: got %h want 02", tt_uo); end
    endtask

    task automatic test_key_slice();
        bus.key = {{120{1'b1}}, 8'h00};
        drive_frame(8'h12, 8'h34, 0, f_byte, f_v9, f_v10, f_ser, f_done, f_busy);
        n_vec++; if (f_byte !== 8'h26) begin n_err++; $display("FAIL key_slice_byte: got %h want 26", f_byte); end
        n_vec++; if (f_ser !== 8'h26) begin n_err++; $display("FAIL key_slice_serial: got %h want 26", f_ser); end
    endtask

    task automatic test_loopback();
        logic [7:0]   a;
        logic [7:0]   b;
        logic [127:0] k;
        for (int i = 0; i <= 256; i++) begin
            if (i == 0) begin
                a = 8'h3C; b = 8'hA5; k = 128'h5A;
            end else begin
                a = 8'($urandom); b = 8'($urandom);
                k = {$urandom, $urandom, $urandom, $urandom};
            end
            bus.key = k;
            // Encryptor model: cipher = A ^ B ^ key[7:0].
            drive_frame(a ^ b ^ k[7:0], b, 0, f_byte, f_v9, f_v10, f_ser, f_done, f_busy);
            n_vec++;
            if ({f_byte, f_ser} !== {a, a}) begin
                n_err++;
                $display("FAIL loopback[%0d]: got byte %h serial %h want %h", i, f_byte, f_ser, a);
            end
        end
    endtask

    task automatic test_back_to_back();
        int         first_t  = -1;
        int         second_t = -1;
        logic [7:0] b1 = 8'hxx;
        logic [7:0] b2 = 8'hxx;
        logic       err_seen = 1'b0;
        bus.key = '0;
        for (int t = 0; t <= 38; t++) begin
            @(negedge clk);
            if (t == 0)  bus.start = 1'b1;
            if (t == 19) bus.start = 1'b0;
            bus.cipher_bit = (t >= 1 && t <= 8);
            bus.b_bit      = 1'b0;
            if (t >= 1) begin
                if (bus.plain_valid === 1'b1) begin
                    if (first_t < 0) begin first_t = t; b1 = bus.plain_byte; end
                    else if (second_t < 0) begin second_t = t; b2 = bus.plain_byte; end
                end
                if (bus.start_err !== 1'b0) err_seen = 1'b1;
            end
        end
        bus.cipher_bit = 1'b0;
        n_vec++; if (first_t !== 10) begin n_err++; $display("FAIL b2b_first_valid_time: got %0d want 10", first_t); end
        n_vec++; if (b1 !== 8'hFF) begin n_err++; $display("FAIL b2b_first_byte: got %h want ff", b1); end
        n_vec++; if (second_t - first_t !== 18) begin n_err++; $display("FAIL b2b_spacing: got %0d want 18", second_t - first_t); end
        n_vec++; if (b2 !== 8'h00) begin n_err++; $display("FAIL b2b_second_byte: got %h want 00", b2); end
        n_vec++; if (err_seen !== 1'b0) begin n_err++; $display("FAIL b2b_start_err: got %b want 0", err_seen); end
        n_vec++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL b2b_done: got %b want 1", bus.done); end
    endtask

    task automatic test_start_busy();
        bus.key = 128'h0F;
        drive_frame(8'hA5, 8'h0F, 5, f_byte, f_v9, f_v10, f_ser, f_done, f_busy);
        n_vec++; if (f_byte !== 8'hA5) begin n_err++; $display("FAIL busy_start_byte: got %h want a5", f_byte); end
        n_vec++; if (f_done !== 1'b1) begin n_err++; $display("FAIL busy_start_done: got %b want 1", f_done); end
        n_vec++; if (bus.start_err !== 1'b1) begin n_err++; $display("FAIL busy_start_err_set: got %b want 1", bus.start_err); end
        drive_frame(8'h3C, 8'h00, 0, f_byte, f_v9, f_v10, f_ser, f_done, f_busy);
        n_vec++; if (f_byte !== 8'h33) begin n_err++; $display("FAIL busy_next_byte: got %h want 33", f_byte); end
        n_vec++; if (bus.start_err !== 1'b1) begin n_err++; $display("FAIL busy_start_err_sticky: got %b want 1", bus.start_err); end
    endtask

    task automatic test_reset_midframe();
        bus.key = 128'h01;
        @(negedge clk);
        bus.start = 1'b1;
        for (int t = 1; t <= 4; t++) begin
            @(negedge clk);
            bus.start      = 1'b0;
            bus.cipher_bit = 1'b1;
            bus.b_bit      = 1'b0;
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (bus.plain_byte !== 8'h00) begin n_err++; $display("FAIL midrst_plain_byte: got %h want 00", bus.plain_byte); end
        n_vec++; if (bus.plain_out !== 1'b0) begin n_err++; $display("FAIL midrst_plain_out: got %b want 0", bus.plain_out); end
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
        n_vec++; if (bus.start_err !== 1'b0) begin n_err++; $display("FAIL midrst_start_err: got %b want 0", bus.start_err); end
        n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL midrst_done: got %b want 0", bus.done); end
        @(negedge clk);
        bus.cipher_bit = 1'b0;
        rst_n = 1'b1;
        drive_frame(8'h81, 8'h00, 0, f_byte, f_v9, f_v10, f_ser, f_done, f_busy);
        n_vec++; if (f_byte !== 8'h80) begin n_err++; $display("FAIL midrst_next_byte: got %h want 80", f_byte); end
        n_vec++; if (f_ser !== 8'h80) begin n_err++; $display("FAIL midrst_next_serial: got %h want 80", f_ser); end
        n_vec++; if (f_done !== 1'b1) begin n_err++; $display("FAIL midrst_next_done: got %b want 1", f_done); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_key_slice();
        test_loopback();
        test_back_to_back();
        test_start_busy();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before summary, got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_secure_serdes_decryptor_core
`default_nettype wire

// File: doc/secure_serdes_decryptor_core.md
# secure_serdes_decryptor_core

Receive-side counterpart of the secure SERDES encryptor. It deserialises an 8-bit cipher frame and the matching 8-bit B operand stream, both MSB first. It recovers the plaintext A byte as cipher ^ B ^ key[7:0], then presents that byte in parallel with a valid pulse and re-serialises it MSB first. It sits behind the same Tiny Tapeout pin wrapper as the encryptor, so a loopback of encryptor `cipher_out` into this block's `cipher_bit` returns the original A stream.

## Interface
- `DATA_W`, default 8: frame width. Only 8 is supported; the 3-bit counters assume it.
- `KEY_W`, default 128: key width. Only bits [DATA_W-1:0] are used.

- `clk` input, 1 bit: single clock, all logic on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `start` input, 1 bit: frame request, sampled only in IDLE.
- `key` input, KEY_W bits: shared secret, must be stable from start to valid.
- `cipher_bit` input, 1 bit: serial cipher stream, MSB first.
- `b_bit` input, 1 bit: serial B operand stream, MSB first, bit-aligned with `cipher_bit`.
- `plain_byte` output, 8 bits: recovered A byte, held until the next DECRYPT.
- `plain_valid` output, 1 bit: one-cycle pulse when `plain_byte` updates.
- `plain_out` output, 1 bit: serial plaintext, MSB first.
- `busy` output, 1 bit: high in any state other than IDLE.
- `done` output, 1 bit: level. Set at frame end, cleared by the next accepted start.
- `start_err` output, 1 bit: sticky. Set when `start` is high while `busy`; cleared only by reset.

## Operation
- States use a 2-bit encoding: IDLE=0, SHIFT=1, DECRYPT=2, OUTPUT=3.
- IDLE:
  - If `start` is high: clear `bit_cnt`, clear the C and B shift registers, clear `done`, go to SHIFT.
  - Otherwise hold.
- SHIFT:
  - Each cycle: C <= {C[6:0], cipher_bit}; B <= {B[6:0], b_bit}; `bit_cnt` increments.
  - Exit to DECRYPT when `bit_cnt` == 7, after exactly 8 samples.
- DECRYPT (one cycle):
  - `plain_byte` <= C ^ B ^ key[7:0].
  - The output shift register loads the same value.
  - `plain_valid` <= 1; `bit_cnt` <= 0; go to OUTPUT.
- OUTPUT:
  - Each cycle: `plain_out` <= shreg[7]; shreg shifts left, zero filled; `bit_cnt` increments.
  - When `bit_cnt` == 7: `done` <= 1 and return to IDLE.
- `plain_valid` is high in the first OUTPUT cycle only.
- `plain_out` holds its last driven bit (bit 0) until the next OUTPUT phase.
- All arithmetic is XOR only. `bit_cnt` is 3 bits and wraps 7→0 naturally.

## Timing
- Reference edges: E0 is the edge where `start` is sampled high in IDLE.
- E1..E8: sample bits 7..0 of `cipher_bit` and `b_bit`.
- E9: DECRYPT. `plain_byte` and `plain_valid` are visible after E9.
- E10..E17: `plain_out` shows bits 7..0, each valid after its edge.
- E17: `done` rises.
- E18: earliest next start sample. A continuously high `start` gives back-to-back 18-cycle frames.
- Latency: last input bit to valid `plain_byte` is 1 cycle. Last input bit to last serial bit is 9 cycles.
- `start` asserted during SHIFT/DECRYPT/OUTPUT: ignored for sequencing and sets `start_err`.
- `start` asserted in IDLE with `done`=1: accepted, and `done` clears at E0.
- Reset mid-frame: immediately returns to IDLE and discards the partial frame. No `done`.
- Reset values, all outputs 0: `plain_byte`=0x00, `plain_valid`=0, `plain_out`=0, `busy`=0, `done`=0, `start_err`=0.
- Reset values, internal state: state=IDLE, C=B=shreg=0, `bit_cnt`=0.
- `key` changes during SHIFT are tolerated; only the value at E9 is used.

## Structure
- Shared package `secure_serdes_pkg` holds:
  - state localparams (IDLE/SHIFT/DECRYPT/OUTPUT, 2-bit);
  - `DATA_W`;
  - the key slice constant `KEY_LSB_W`=8.
- The encryptor core also moves to this package.
- One sub-module, `secure_serdes_shift8`: 8-bit MSB-first shift register with clear and parallel load.
  - Instantiated three times: C in, B in, plaintext out.
- Pin wrapper `tt_um_secure_serdes_decryptor`:
  - inputs: ui_in[0]=start, ui_in[1]=cipher_bit, ui_in[2]=b_bit;
  - serial/status outputs: uo_out[0]=plain_out, uo_out[1]=done, uo_out[2]=busy, uo_out[3]=start_err;
  - parallel byte: uio_out=plain_byte, uio_oe=0xFF.

## Test plan
- Basic decrypt: key[7:0]=0x5A, cipher=0xC3, B=0xA5 → `plain_byte`=0x3C with `plain_valid` high for 1 cycle after E9; `plain_out` sequence 0,0,1,1,1,1,0,0 on E10..E17; `done`=1 after E17.
- Loopback: encryptor with A=0x3C, B=0xA5, key=0x5A feeds `cipher_bit`, with B delayed to align → `plain_byte`=0x3C; repeat over 256 random A values, all match.
- Back-to-back: `start` held high, frames 0xFF/0x00 then 0x00/0x00 with key=0 → `plain_byte` 0xFF then 0x00; second `plain_valid` exactly 18 cycles after the first; `start_err` stays 0.
- Start while busy: pulse `start` at E5 → frame result unchanged, `start_err`=1 and sticky across further frames until `rst_n` low.
- Reset mid-frame: assert `rst_n` low at E4 → all outputs 0 asynchronously; after release, a new frame with cipher=0x81, B=0x00, key=0x01 gives `plain_byte`=0x80.
- Key slice: key=128'hFFFF…FF00 with cipher=0x12, B=0x34 → `plain_byte`=0x26, confirming upper key bits are unused.
